// File: rtl/mem_wb_stage.sv
//
// mem_wb_stage
// ------------
// Memory / write-back stage of a small in-order pipeline. It takes one
// instruction at a time from the MEM stage and commits it to the register
// file. An ALU instruction commits on the cycle after it is accepted. A load
// parks in WAIT_LOAD until the data memory answers, then commits on the
// following cycle. A commit in progress can accept the next instruction, so
// back-to-back ALU instructions retire one per cycle.
//
// Optional feature macro: LOAD_SUBWORD_EN
//   defined   : LB/LBU/LH/LHU pick a big-endian byte or halfword out of the
//               read word and sign- or zero-extend it.
//   undefined : every load returns dmem_rdata unchanged (plain LW).
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous, active-low reset
//   in_valid       MEM stage presents an instruction
//   in_ready       stage accepts the presented instruction this cycle
//   in_wreg        instruction writes a register
//   in_rd_addr     destination register
//   in_alu_result  result of a non-load instruction
//   in_is_load     instruction is a load
//   in_load_op     0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU (5-7 act as LW)
//   in_addr_lo     byte offset of the load address
//   dmem_rvalid    data memory read response valid
//   dmem_rdata     data memory read word
//   dec_rs_addr    decode-stage rs address
//   dec_rt_addr    decode-stage rt address
//   write_en       register file write enable
//   rd_addr        register file write address
//   rd_data        register file write data
//   load_use_stall decode must hold (pending load targets one of its sources)
//   retired        one-cycle pulse for every committed instruction
//
// The sub-word extraction assumes W >= 32.

module mem_wb_stage #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_wreg,
    input  logic [RW-1:0] in_rd_addr,
    input  logic [W-1:0]  in_alu_result,
    input  logic          in_is_load,
    input  logic [2:0]    in_load_op,
    input  logic [1:0]    in_addr_lo,
    input  logic          dmem_rvalid,
    input  logic [W-1:0]  dmem_rdata,
    input  logic [RW-1:0] dec_rs_addr,
    input  logic [RW-1:0] dec_rt_addr,
    output logic          write_en,
    output logic [RW-1:0] rd_addr,
    output logic [W-1:0]  rd_data,
    output logic          load_use_stall,
    output logic          retired
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LOAD,
        COMMIT
    } state_t;

    state_t         state;
    logic           pend_wreg;
    logic           accept;
    logic [W-1:0]   load_word;
    logic           pend_hit;
    logic           pres_hit;

    // While held in reset the stage looks ready and never stalls decode,
    // independent of whatever the state register currently holds.
    assign in_ready = !rst || (state != WAIT_LOAD);
    assign accept   = in_valid && in_ready;

`ifdef LOAD_SUBWORD_EN
    logic [2:0] pend_op;
    logic [1:0] pend_lo;

    // Big-endian lanes: offset 0 is the most significant byte. The halfword
    // lane is chosen by the upper offset bit alone.
    function automatic logic [W-1:0] extract_load(
        input logic [W-1:0] word,
        input logic [2:0]   op,
        input logic [1:0]   lo
    );
        logic [W-1:0] byte_shift;
        logic [W-1:0] half_shift;
        logic [7:0]   b;
        logic [15:0]  h;
        byte_shift = word >> (W - 8 * (int'(lo) + 1));
        half_shift = word >> (lo[1] ? (W - 32) : (W - 16));
        b = byte_shift[7:0];
        h = half_shift[15:0];
        case (op)
            3'd1:    extract_load = {{(W-8){b[7]}}, b};
            3'd2:    extract_load = {{(W-8){1'b0}}, b};
            3'd3:    extract_load = {{(W-16){h[15]}}, h};
            3'd4:    extract_load = {{(W-16){1'b0}}, h};
            default: extract_load = word;
        endcase
    endfunction

    // Remember how the load wants its data sliced until the response arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pend_op <= '0;
            pend_lo <= '0;
        end else if (accept && in_is_load) begin
            pend_op <= in_load_op;
            pend_lo <= in_addr_lo;
        end
    end

    assign load_word = extract_load(dmem_rdata, pend_op, pend_lo);
`else
    logic unused_subword;
    assign unused_subword = ^{in_load_op, in_addr_lo};
    assign load_word      = dmem_rdata;
`endif

    // Main control: accept in IDLE/COMMIT, wait for the memory in WAIT_LOAD,
    // and raise the registered commit outputs on the edge entering COMMIT.
    // rd_addr is captured at accept; rd_data is captured at accept for ALU
    // instructions and on the response edge for loads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            write_en  <= 1'b0;
            retired   <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
            pend_wreg <= 1'b0;
        end else begin
            write_en <= 1'b0;
            retired  <= 1'b0;
            case (state)
                IDLE, COMMIT: begin
                    if (accept) begin
                        rd_addr   <= in_rd_addr;
                        pend_wreg <= in_wreg;
                        if (in_is_load) begin
                            state <= WAIT_LOAD;
                        end else begin
                            state    <= COMMIT;
                            rd_data  <= in_alu_result;
                            write_en <= in_wreg && (in_rd_addr != '0);
                            retired  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_LOAD: begin
                    if (dmem_rvalid) begin
                        state    <= COMMIT;
                        rd_data  <= load_word;
                        write_en <= pend_wreg && (rd_addr != '0);
                        retired  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A load that will write a real register stalls decode if decode reads
    // that register, whether it is already waiting here or is only being
    // presented this cycle.
    assign pend_hit = (state == WAIT_LOAD) && pend_wreg && (rd_addr != '0) &&
                      ((rd_addr == dec_rs_addr) || (rd_addr == dec_rt_addr));
    assign pres_hit = in_valid && in_is_load && in_wreg && (in_rd_addr != '0) &&
                      ((in_rd_addr == dec_rs_addr) || (in_rd_addr == dec_rt_addr));
    assign load_use_stall = rst && (pend_hit || pres_hit);

endmodule

// File: tb/tb_mem_wb_stage.sv
//
// tb_mem_wb_stage
// ---------------
// Self-checking bench for mem_wb_stage: a table of directed vectors, a
// hand-written reset-during-load sequence, and a randomized run compared
// against a transaction-level reference model.

module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wreg;
    logic [4:0]  in_rd_addr;
    logic [31:0] in_alu_result;
    logic        in_is_load;
    logic [2:0]  in_load_op;
    logic [1:0]  in_addr_lo;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic [4:0]  dec_rs_addr;
    logic [4:0]  dec_rt_addr;
    logic        write_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        load_use_stall;
    logic        retired;

    int checks = 0;
    int errors = 0;

`ifdef LOAD_SUBWORD_EN
    localparam bit SUBWORD_ON = 1'b1;
`else
    localparam bit SUBWORD_ON = 1'b0;
`endif

    mem_wb_stage #(.W(32), .RW(5)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_wreg       (in_wreg),
        .in_rd_addr    (in_rd_addr),
        .in_alu_result (in_alu_result),
        .in_is_load    (in_is_load),
        .in_load_op    (in_load_op),
        .in_addr_lo    (in_addr_lo),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
        .dec_rs_addr   (dec_rs_addr),
        .dec_rt_addr   (dec_rt_addr),
        .write_en      (write_en),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .load_use_stall(load_use_stall),
        .retired       (retired)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    typedef struct {
        bit          rst_n;
        bit          valid;
        bit          wreg;
        logic [4:0]  rd;
        logic [31:0] alu;
        bit          is_load;
        logic [2:0]  op;
        logic [1:0]  lo;
        bit          rvalid;
        logic [31:0] rdata;
        logic [4:0]  rs;
        logic [4:0]  rt;
        bit          e_ready;
        bit          e_stall;
        bit          e_we;
        bit          e_ret;
        bit          chk;
        logic [4:0]  e_rd;
        logic [31:0] e_data;
    } vec_t;

    function automatic vec_t mkVec(
        input bit rst_n, input bit valid, input bit wreg, input logic [4:0] rd,
        input logic [31:0] alu, input bit is_load, input logic [2:0] op,
        input logic [1:0] lo, input bit rvalid, input logic [31:0] rdata,
        input logic [4:0] rs, input logic [4:0] rt,
        input bit e_ready, input bit e_stall, input bit e_we, input bit e_ret,
        input bit chk, input logic [4:0] e_rd, input logic [31:0] e_data
    );
        vec_t v;
        v.rst_n = rst_n;  v.valid = valid;  v.wreg = wreg;  v.rd = rd;
        v.alu = alu;      v.is_load = is_load; v.op = op;   v.lo = lo;
        v.rvalid = rvalid; v.rdata = rdata; v.rs = rs;      v.rt = rt;
        v.e_ready = e_ready; v.e_stall = e_stall; v.e_we = e_we;
        v.e_ret = e_ret;  v.chk = chk;      v.e_rd = e_rd;  v.e_data = e_data;
        return v;
    endfunction

    // Reference load result: view the word as four bytes, byte 0 being the
    // most significant, and apply the RISC-style load semantics directly.
    function automatic logic [31:0] refLoad(
        input logic [2:0] op, input logic [1:0] lo, input logic [31:0] word
    );
        logic [7:0]  bytes [4];
        logic [15:0] half;
        logic [31:0] sub;
        for (int i = 0; i < 4; i++) bytes[i] = word[31 - 8*i -: 8];
        half = {bytes[{lo[1], 1'b0}], bytes[{lo[1], 1'b1}]};
        case (op)
            3'd1:    sub = int'($signed(bytes[lo]));
            3'd2:    sub = {24'h0, bytes[lo]};
            3'd3:    sub = int'($signed(half));
            3'd4:    sub = {16'h0, half};
            default: sub = word;
        endcase
        return SUBWORD_ON ? sub : word;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        rst           = v.rst_n;
        in_valid      = v.valid;
        in_wreg       = v.wreg;
        in_rd_addr    = v.rd;
        in_alu_result = v.alu;
        in_is_load    = v.is_load;
        in_load_op    = v.op;
        in_addr_lo    = v.lo;
        dmem_rvalid   = v.rvalid;
        dmem_rdata    = v.rdata;
        dec_rs_addr   = v.rs;
        dec_rt_addr   = v.rt;
    endtask

    // One clock: drive at the falling edge, check combinational outputs just
    // after, then check registered outputs just after the rising edge.
    task automatic runCycle(input vec_t v, input string tag);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput({tag, " in_ready"}, 32'(in_ready), 32'(v.e_ready));
        checkOutput({tag, " load_use_stall"}, 32'(load_use_stall), 32'(v.e_stall));
        @(posedge clk);
        #1;
        checkOutput({tag, " write_en"}, 32'(write_en), 32'(v.e_we));
        checkOutput({tag, " retired"}, 32'(retired), 32'(v.e_ret));
        if (v.chk) begin
            checkOutput({tag, " rd_addr"}, 32'(rd_addr), 32'(v.e_rd));
            checkOutput({tag, " rd_data"}, rd_data, v.e_data);
        end
    endtask

    vec_t table_q[$];

    // Reference model: the stage either holds nothing or holds one load
    // that is waiting for memory data.
    bit          holding;
    bit          h_wreg;
    logic [4:0]  h_rd;
    logic [2:0]  h_op;
    logic [1:0]  h_lo;

    initial begin
        logic [31:0] lbExp, lhuExp, lhExp;
        lbExp  = SUBWORD_ON ? 32'hFFFFFF80 : 32'h0080FF00;
        lhuExp = SUBWORD_ON ? 32'h0000F678 : 32'h1234F678;
        lhExp  = SUBWORD_ON ? 32'hFFFF8001 : 32'h8001FFFF;

        applyStimulus(mkVec(0,0,0,0,0,0,0,0,0,0,0,0, 1,0,0,0,0,0,0));

        // rst vld wr rd  alu            ld op lo rv rdata          rs rt | rdy stl we ret chk rd data
        table_q.push_back(mkVec(0,1,1,5, 32'h0,        1,0,0,0,32'h0,        5,5, 1,0,0,0,1,0,32'h0));
        table_q.push_back(mkVec(1,1,1,8, 32'h12345678, 0,0,0,0,32'h0,        0,0, 1,0,1,1,1,8,32'h12345678));
        table_q.push_back(mkVec(1,1,1,1, 32'hA1,       0,0,0,0,32'h0,        0,0, 1,0,1,1,1,1,32'hA1));
        table_q.push_back(mkVec(1,1,0,2, 32'hB2,       0,0,0,0,32'h0,        0,0, 1,0,0,1,1,2,32'hB2));
        table_q.push_back(mkVec(1,1,1,3, 32'hC3,       0,0,0,0,32'h0,        0,0, 1,0,1,1,1,3,32'hC3));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,0,32'h0,        0,0, 1,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,1,1,9, 32'h0,        1,1,1,1,32'hEEEEEEEE, 0,0, 1,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,0,32'h0,        0,0, 0,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,1,1,4, 32'h77,       0,0,0,0,32'h0,        0,0, 0,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,0,32'h0,        0,0, 0,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,1,32'h0080FF00, 0,0, 0,0,1,1,1,9,lbExp));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,0,32'h0,        0,0, 1,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,1,1,5, 32'h0,        1,0,0,0,32'h0,        0,5, 1,1,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,0,32'h0,        0,5, 0,1,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,1,32'hDEADBEEF, 0,5, 0,1,1,1,1,5,32'hDEADBEEF));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,0,32'h0,        0,5, 1,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,1,1,0, 32'h0,        1,0,0,0,32'h0,        0,0, 1,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,0,32'h0,        0,0, 0,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,1,32'h55,       0,0, 0,0,0,1,1,0,32'h55));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,0,32'h0,        0,0, 1,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,1,1,4, 32'h0,        1,4,2,0,32'h0,        4,0, 1,1,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,1,32'h1234F678, 4,0, 0,1,1,1,1,4,lhuExp));
        table_q.push_back(mkVec(1,1,1,6, 32'h0,        1,3,1,0,32'h0,        0,0, 1,0,0,0,0,0,32'h0));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,1,32'h8001FFFF, 0,0, 0,0,1,1,1,6,lhExp));
        table_q.push_back(mkVec(1,0,0,0, 32'h0,        0,0,0,0,32'h0,        0,0, 1,0,0,0,0,0,32'h0));

        for (int i = 0; i < table_q.size(); i++)
            runCycle(table_q[i], $sformatf("vec%0d", i));

        // Reset while a load waits: the load is dropped and the late memory
        // response must not produce a commit.
        runCycle(mkVec(1,1,1,7,32'h0,1,0,0,0,32'h0,        7,0, 1,1,0,0,0,0,32'h0), "rstload accept");
        runCycle(mkVec(1,0,0,0,32'h0,0,0,0,0,32'h0,        0,7, 0,1,0,0,0,0,32'h0), "rstload wait");
        runCycle(mkVec(0,1,1,7,32'h0,1,0,0,0,32'h0,        0,7, 1,0,0,0,1,0,32'h0), "rstload reset");
        runCycle(mkVec(1,0,0,0,32'h0,0,0,0,1,32'hCAFEF00D, 0,7, 1,0,0,0,0,0,32'h0), "rstload late");
        runCycle(mkVec(1,0,0,0,32'h0,0,0,0,0,32'h0,        0,7, 1,0,0,0,0,0,32'h0), "rstload idle");

        // Randomized run against the reference model.
        holding = 1'b0;
        h_wreg  = 1'b0;
        h_rd    = '0;
        h_op    = '0;
        h_lo    = '0;
        for (int n = 0; n < 600; n++) begin
            vec_t v;
            v.rst_n   = (n == 0) ? 1'b0 : ($urandom_range(0, 29) != 0);
            v.valid   = $urandom_range(0, 1) == 1;
            v.wreg    = $urandom_range(0, 3) != 0;
            v.rd      = 5'($urandom_range(0, 7));
            v.alu     = $urandom;
            v.is_load = $urandom_range(0, 4) < 2;
            v.op      = 3'($urandom_range(0, 7));
            v.lo      = 2'($urandom_range(0, 3));
            v.rvalid  = $urandom_range(0, 2) == 0;
            v.rdata   = $urandom;
            v.rs      = 5'($urandom_range(0, 7));
            v.rt      = 5'($urandom_range(0, 7));

            v.e_ready = !v.rst_n || !holding;
            v.e_stall = v.rst_n &&
                ((holding && h_wreg && h_rd != 0 && (h_rd == v.rs || h_rd == v.rt)) ||
                 (v.valid && v.is_load && v.wreg && v.rd != 0 &&
                  (v.rd == v.rs || v.rd == v.rt)));
            v.e_we = 1'b0; v.e_ret = 1'b0; v.chk = 1'b0; v.e_rd = '0; v.e_data = '0;

            if (!v.rst_n) begin
                holding = 1'b0;
                v.chk   = 1'b1;
            end else if (holding) begin
                if (v.rvalid) begin
                    holding  = 1'b0;
                    v.e_ret  = 1'b1;
                    v.e_we   = h_wreg && h_rd != 0;
                    v.chk    = 1'b1;
                    v.e_rd   = h_rd;
                    v.e_data = refLoad(h_op, h_lo, v.rdata);
                end
            end else if (v.valid) begin
                if (v.is_load) begin
                    holding = 1'b1;
                    h_wreg  = v.wreg;
                    h_rd    = v.rd;
                    h_op    = v.op;
                    h_lo    = v.lo;
                end else begin
                    v.e_ret  = 1'b1;
                    v.e_we   = v.wreg && v.rd != 0;
                    v.chk    = 1'b1;
                    v.e_rd   = v.rd;
                    v.e_data = v.alu;
                end
            end
            runCycle(v, $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter W, default 32: data word width.
REQ-002 SHALL have parameter RW, default 5: register address width.
REQ-003 SHALL have port clk, input, 1: rising-edge clock for all state.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1: MEM stage presents an instruction.
REQ-006 SHALL have port in_ready, output, 1: stage accepts the instruction this cycle.
REQ-007 SHALL have port in_wreg, input, 1: instruction writes a register.
REQ-008 SHALL have port in_rd_addr, input, RW: destination register.
REQ-009 SHALL have port in_alu_result, input, W: non-load result.
REQ-010 SHALL have port in_is_load, input, 1: instruction is a load.
REQ-011 SHALL have port in_load_op, input, 3: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU.
REQ-012 SHALL have port in_addr_lo, input, 2: load byte offset.
REQ-013 SHALL have port dmem_rvalid, input, 1: data memory read response valid.
REQ-014 SHALL have port dmem_rdata, input, W: data memory read word.
REQ-015 SHALL have port dec_rs_addr, input, RW: decode rs address.
REQ-016 SHALL have port dec_rt_addr, input, RW: decode rt address.
REQ-017 SHALL have port write_en, output, 1: regfile write enable.
REQ-018 SHALL have port rd_addr, output, RW: regfile write address.
REQ-019 SHALL have port rd_data, output, W: regfile write data.
REQ-020 SHALL have port load_use_stall, output, 1: decode must hold.
REQ-021 SHALL have port retired, output, 1: one-cycle commit pulse.

Function
REQ-022 SHALL use FSM states IDLE, WAIT_LOAD, COMMIT.
REQ-023 SHALL drive in_ready high in IDLE and COMMIT, and low in WAIT_LOAD.
REQ-024 SHALL accept when in_valid and in_ready; a non-load then goes to COMMIT next cycle, and a load goes to WAIT_LOAD.
REQ-025 SHALL leave WAIT_LOAD for COMMIT on the cycle after dmem_rvalid, latching the extracted data; otherwise it stays, with no timeout.
REQ-026 SHALL ignore dmem_rvalid outside WAIT_LOAD, including the accept cycle.
REQ-027 SHALL, from COMMIT with no accept, go to IDLE; an accept in COMMIT chains back-to-back, giving ALU throughput of 1 per cycle.
REQ-028 SHALL assert write_en only in COMMIT, and only with latched wreg=1 and rd_addr!=0; rd_addr and rd_data are latched values.
REQ-029 SHALL pulse retired for every COMMIT cycle regardless of wreg.
REQ-030 SHALL set rd_data to in_alu_result for non-loads and to the extracted word for loads.
REQ-031 SHALL extract big-endian: offset 0 selects bits W-1:W-8 (byte) and W-1:W-16 (half); the half select uses in_addr_lo[1] only.
REQ-032 SHALL sign-extend LB/LH and zero-extend LBU/LHU; codes 5-7 behave as LW.
REQ-033 SHALL drive load_use_stall combinationally high when a load with wreg=1 and rd!=0, pending in WAIT_LOAD or presented with in_valid and in_is_load, matches dec_rs_addr or dec_rt_addr.

Reset
REQ-034 SHALL, on rst=0 at a clock edge, enter IDLE and clear write_en, retired, rd_addr and rd_data.
REQ-035 SHALL drop a pending load on reset mid-operation, with no commit; a late dmem_rvalid is then ignored.
REQ-036 SHALL produce in_ready=1 and load_use_stall=0 from inputs only while held in reset.

Configuration
REQ-037 SHALL implement sub-word extraction (REQ-031, REQ-032) only when LOAD_SUBWORD_EN is defined.
REQ-038 SHALL, without LOAD_SUBWORD_EN, treat every load_op as LW and use dmem_rdata unmodified; the FSM is unchanged.

Verification
REQ-039 SHALL verify: ALU op rd=8, result 0x12345678 accepted at cycle T -> write_en=1, rd_addr=8, rd_data=0x12345678 at T+1.
REQ-040 SHALL verify: three ALU ops on consecutive cycles -> three consecutive commits, in_ready constantly 1.
REQ-041 SHALL verify: LB offset 1, dmem_rdata 0x0080FF00 after 3 wait cycles -> in_ready=0 for 4 cycles, then rd_data=0xFFFFFF80 (0x0080FF00 without LOAD_SUBWORD_EN).
REQ-042 SHALL verify: LW rd=5 pending, dec_rt_addr=5 -> load_use_stall=1 until the COMMIT cycle; rd=0 -> stall=0 and write_en=0.
REQ-043 SHALL verify: rst=0 asserted during WAIT_LOAD, then dmem_rvalid -> no write_en, state IDLE, in_ready=1.
